// File: rtl/euler1_pkg.sv
// Shared definitions for the euler1 job sequencer: FSM state encoding,
// default bus widths and the solver reset hold time.
package euler1_pkg;

    localparam int MAX_W_DEF = 16;   // job bound width
    localparam int RES_W_DEF = 24;   // solver sum width
    localparam int RST_CYC   = 2;    // cycles the solver is held in reset per job
    localparam int TO_W      = 17;   // watchdog counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/euler1_ctrl_wdog.sv
// RUN-state watchdog for the euler1 sequencer. The counter sits at zero
// outside RUN, so it is cleared on every RUN entry, and counts each RUN
// cycle. expired_o flags the cycle on which the limit is reached.
module euler1_ctrl_wdog
    import euler1_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 70000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run_i,
    output logic expired_o
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Next count: increment while running, hold at zero otherwise.
    always_comb begin
        cnt_d = run_i ? cnt_q + 1'b1 : '0;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    // Leaving RUN on this edge puts the RESP entry exactly TIMEOUT_CYC edges after RUN entry.
    assign expired_o = run_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/euler1_ctrl.sv
// euler1_ctrl: host-side job sequencer for the euler1 solver.
// Accepts one job on the req port, holds the solver in reset for RST_CYC
// cycles, runs it until results_valid, and returns the sum on the rsp port.
// Optional watchdog: define EULER1_CTRL_TIMEOUT_EN to abort RUN after
// TIMEOUT_CYC cycles with rsp_timeout=1 and a zero result.
module euler1_ctrl
    import euler1_pkg::*;
#(
    parameter int          MAX_W       = MAX_W_DEF,
    parameter int          RES_W       = RES_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 70000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [MAX_W-1:0] req_max,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic [MAX_W-1:0] rsp_max,
    output logic             rsp_timeout,
    output logic [7:0]       done_cnt,
    output logic             slv_reset,
    output logic             slv_enable,
    output logic [MAX_W-1:0] slv_max_value,
    input  logic             slv_results_valid,
    input  logic [RES_W-1:0] slv_results
);

    state_e           state_q, state_d;
    logic [1:0]       rst_cnt_q, rst_cnt_d;
    logic             ready_en_q;
    logic [MAX_W-1:0] slv_max_q, slv_max_d;
    logic [MAX_W-1:0] rsp_max_q, rsp_max_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       done_q, done_d;
    logic             wdog_expired;

`ifdef EULER1_CTRL_TIMEOUT_EN
    euler1_ctrl_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .run_i     (state_q == ST_RUN),
        .expired_o (wdog_expired)
    );
`else
    assign wdog_expired = 1'b0;
`endif

    // Next-state and output decode for the IDLE -> RST -> RUN -> RESP loop.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        slv_max_d  = slv_max_q;
        rsp_max_d  = rsp_max_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        done_d     = done_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        slv_reset  = 1'b1;
        slv_enable = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // ready_en_q keeps req_ready low until the first edge after reset release.
                req_ready = ready_en_q;
                if (req_valid && ready_en_q) begin
                    slv_max_d = req_max;
                    rsp_max_d = req_max;
                    rst_cnt_d = '0;
                    if (req_max == '0) begin
                        // The solver never terminates for a zero bound; answer directly.
                        result_d = '0;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_RST;
                    end
                end
            end
            ST_RST: begin
                rst_cnt_d = rst_cnt_q + 2'd1;
                if (rst_cnt_q == 2'(RST_CYC - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                slv_reset  = 1'b0;
                slv_enable = 1'b1;
                // Solver registers result and valid together, so capture on the same sample.
                if (slv_results_valid) begin
                    result_d = slv_results;
                    state_d  = ST_RESP;
                end else if (wdog_expired) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    done_d    = done_q + 8'd1;
                    timeout_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; async reset drops any job in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rst_cnt_q  <= '0;
            ready_en_q <= 1'b0;
            slv_max_q  <= '0;
            rsp_max_q  <= '0;
            result_q   <= '0;
            timeout_q  <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            ready_en_q <= 1'b1;
            slv_max_q  <= slv_max_d;
            rsp_max_q  <= rsp_max_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
        end
    end

    assign slv_max_value = slv_max_q;
    assign rsp_max       = rsp_max_q;
    assign rsp_result    = result_q;
    assign rsp_timeout   = timeout_q;
    assign done_cnt      = done_q;

endmodule
